// File: rtl/issue_scheduler_pkg.sv
// spu_pkg: shared types, sizes and helpers for the dual-issue scheduler
package spu_pkg;
  localparam int NUM_REGS = 128;
  localparam int LAT_MAX = 7;
  localparam int REG_W = $clog2(NUM_REGS);
  typedef struct packed {
    logic v;
    logic wr;
    logic pipe;
    logic [2:0] lat;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic use_a;
    logic use_b;
    logic use_c;
  } issue_info_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} sched_state_t;
  function automatic logic reads_reg(issue_info_t i, logic [REG_W-1:0] r);
    return (i.use_a && i.ra == r) || (i.use_b && i.rb == r) || (i.use_c && i.rc == r);
  endfunction
  function automatic logic [2:0] eff_lat(logic [2:0] lat);
    return lat == 3'd0 ? 3'd1 : (32'(lat) > LAT_MAX ? 3'(LAT_MAX) : lat);
  endfunction
endpackage

// File: rtl/issue_scheduler_if.sv
// issue_scheduler_if: decode-side pair input (in_valid/in_ready/in0/in1) and even/odd issue outputs with stall
interface issue_scheduler_if;
  logic in_valid;
  logic in_ready;
  spu_pkg::issue_info_t in0_info;
  spu_pkg::issue_info_t in1_info;
  logic even_valid;
  spu_pkg::issue_info_t even_info;
  logic odd_valid;
  spu_pkg::issue_info_t odd_info;
  logic stall;
  modport master (
    output in_valid, in0_info, in1_info,
    input in_ready, even_valid, even_info, odd_valid, odd_info, stall
  );
  modport slave (
    input in_valid, in0_info, in1_info,
    output in_ready, even_valid, even_info, odd_valid, odd_info, stall
  );
endinterface

// File: rtl/issue_scheduler_scoreboard.sv
// scoreboard: per-register latency counters (clk, reset, flush_i, two load ports, busy_o); a count of 1 expires on the reader's issue edge, so only counts above 1 mark busy
module scoreboard
  import spu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                ld0_i,
  input  logic [REG_W-1:0]    ld0_reg_i,
  input  logic [2:0]          ld0_lat_i,
  input  logic                ld1_i,
  input  logic [REG_W-1:0]    ld1_reg_i,
  input  logic [2:0]          ld1_lat_i,
  output logic [NUM_REGS-1:0] busy_o
);
  logic [2:0] cnt_q [NUM_REGS];
  logic [2:0] cnt_d [NUM_REGS];
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = flush_i ? 3'd0 :
                 (ld0_i && ld0_reg_i == REG_W'(r)) ? ld0_lat_i :
                 (ld1_i && ld1_reg_i == REG_W'(r)) ? ld1_lat_i :
                 (cnt_q[r] != 3'd0) ? cnt_q[r] - 3'd1 : 3'd0;
      busy_o[r] = cnt_q[r] > 3'd1;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: two-entry in-order buffer issuing to even/odd pipes with scoreboard hazard checks (clk, reset, flush, bus: issue_scheduler_if.slave)
module issue_scheduler
  import spu_pkg::*;
(
  input logic              clk,
  input logic              reset,
  input logic              flush,
  issue_scheduler_if.slave bus
);
  sched_state_t state_q, state_d;
  issue_info_t old_q, old_d, yng_q, yng_d;
  issue_info_t even_info_q, even_info_d, odd_info_q, odd_info_d;
  logic even_valid_q, even_valid_d, odd_valid_q, odd_valid_d, stall_q, stall_d;
  logic [NUM_REGS-1:0] busy;
  logic accept, old_ok, yng_ok, iss0, iss1;
  function automatic logic clear(issue_info_t i, logic [NUM_REGS-1:0] b);
    return !(i.use_a && b[i.ra]) && !(i.use_b && b[i.rb]) && !(i.use_c && b[i.rc]) && !(i.wr && b[i.rt]);
  endfunction
  assign bus.in_ready = state_q == EMPTY;
  assign accept = bus.in_valid && bus.in_ready && !flush;
  assign old_ok = state_q != EMPTY && clear(old_q, busy);
  assign yng_ok = state_q == TWO && clear(yng_q, busy) && yng_q.pipe != old_q.pipe &&
                  !(old_q.wr && (reads_reg(yng_q, old_q.rt) || (yng_q.wr && yng_q.rt == old_q.rt)));
  assign iss0 = old_ok && !flush;
  assign iss1 = iss0 && yng_ok;
  scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (flush),
    .ld0_i     (iss0 && old_q.wr),
    .ld0_reg_i (old_q.rt),
    .ld0_lat_i (eff_lat(old_q.lat)),
    .ld1_i     (iss1 && yng_q.wr),
    .ld1_reg_i (yng_q.rt),
    .ld1_lat_i (eff_lat(yng_q.lat)),
    .busy_o    (busy)
  );
  always_comb begin
    state_d = state_q;
    old_d = old_q;
    yng_d = yng_q;
    if (flush) state_d = EMPTY;
    else if (accept) begin
      old_d = bus.in0_info;
      yng_d = bus.in1_info;
      state_d = bus.in1_info.v ? TWO : ONE;
    end else if (state_q == ONE && iss0) state_d = EMPTY;
    else if (state_q == TWO && iss0) begin
      state_d = iss1 ? EMPTY : ONE;
      old_d = yng_q;
    end
    even_valid_d = (iss0 && !old_q.pipe) || (iss1 && !yng_q.pipe);
    even_info_d = (iss0 && !old_q.pipe) ? old_q : (iss1 && !yng_q.pipe) ? yng_q : '0;
    odd_valid_d = (iss0 && old_q.pipe) || (iss1 && yng_q.pipe);
    odd_info_d = (iss0 && old_q.pipe) ? old_q : (iss1 && yng_q.pipe) ? yng_q : '0;
    stall_d = state_q != EMPTY && !iss0 && !flush;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= EMPTY;
      old_q <= '0;
      yng_q <= '0;
      even_valid_q <= 1'b0;
      even_info_q <= '0;
      odd_valid_q <= 1'b0;
      odd_info_q <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      old_q <= old_d;
      yng_q <= yng_d;
      even_valid_q <= even_valid_d;
      even_info_q <= even_info_d;
      odd_valid_q <= odd_valid_d;
      odd_info_q <= odd_info_d;
      stall_q <= stall_d;
    end
  assign bus.even_valid = even_valid_q;
  assign bus.even_info = even_info_q;
  assign bus.odd_valid = odd_valid_q;
  assign bus.odd_info = odd_info_q;
  assign bus.stall = stall_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed table plus multi-cycle hazard sequences for issue_scheduler
module tb_issue_scheduler;
  import spu_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  issue_scheduler_if bus ();
  issue_scheduler dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus));
  typedef struct {
    string name;
    issue_info_t i0;
    issue_info_t i1;
    int ev;
    int od;
  } vec_t;
  vec_t vecs [10];
  function automatic issue_info_t mk(logic wr, logic pipe, logic [2:0] lat, logic [6:0] rt, logic [6:0] ra,
                                     logic [6:0] rb, logic [6:0] rc, logic [2:0] uses);
    issue_info_t x;
    x = '{v: 1'b1, wr: wr, pipe: pipe, lat: lat, rt: rt, ra: ra, rb: rb, rc: rc,
          use_a: uses[2], use_b: uses[1], use_c: uses[0]};
    return x;
  endfunction
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic present(input issue_info_t a, input issue_info_t b);
    bus.in0_info = a;
    bus.in1_info = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask
  task automatic wait_valid(input string n, input bit odd, output int t);
    for (int k = 0; k < 30 && !(odd ? bus.odd_valid : bus.even_valid); k++) step();
    if (!(odd ? bus.odd_valid : bus.even_valid)) chk({n, "_timeout"}, 0, 1);
    t = cyc;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int tw, tr;
    issue_info_t w, r, r2;
    bus.in_valid = 1'b0;
    bus.in0_info = '0;
    bus.in1_info = '0;
    vecs[0] = '{"indep",     mk(1, 0, 2, 3, 1, 2, 0, 3'b110),   mk(1, 1, 6, 4, 5, 0, 0, 3'b100),    1, 2};
    vecs[1] = '{"same_pipe", mk(1, 0, 1, 3, 1, 0, 0, 3'b100),   mk(1, 0, 1, 4, 2, 0, 0, 3'b100),    1, 0};
    vecs[2] = '{"intra_raw", mk(1, 0, 2, 3, 1, 2, 0, 3'b110),   mk(1, 1, 1, 6, 0, 3, 0, 3'b010),    1, 0};
    vecs[3] = '{"intra_waw", mk(1, 0, 3, 8, 1, 0, 0, 3'b100),   mk(1, 1, 2, 8, 2, 0, 0, 3'b100),    1, 0};
    vecs[4] = '{"single",    mk(1, 1, 4, 9, 1, 0, 0, 3'b100),   issue_info_t'('0),                 0, 1};
    vecs[5] = '{"odd_first", mk(1, 1, 3, 11, 12, 0, 0, 3'b100), mk(1, 0, 3, 13, 14, 0, 0, 3'b100),  2, 1};
    vecs[6] = '{"unused_src", mk(1, 0, 3, 20, 1, 0, 0, 3'b100), mk(1, 1, 1, 21, 20, 20, 20, 3'b000), 1, 2};
    vecs[7] = '{"old_no_wr", mk(0, 0, 3, 22, 1, 0, 0, 3'b100),  mk(1, 1, 1, 23, 22, 0, 0, 3'b100),  1, 2};
    vecs[8] = '{"reg0_rc",   mk(1, 1, 2, 0, 1, 0, 0, 3'b100),   mk(1, 0, 1, 5, 9, 9, 0, 3'b001),    0, 1};
    vecs[9] = '{"war_ok",    mk(1, 0, 2, 30, 31, 0, 0, 3'b100), mk(1, 1, 2, 31, 1, 0, 0, 3'b100),   1, 2};
    step();
    step();
    chk("rst_even_valid", bus.even_valid, 0);
    chk("rst_odd_valid", bus.odd_valid, 0);
    chk("rst_even_info", bus.even_info, 0);
    chk("rst_odd_info", bus.odd_info, 0);
    chk("rst_stall", bus.stall, 0);
    reset = 1'b1;
    chk("post_rst_ready", bus.in_ready, 1);
    foreach (vecs[k]) begin
      present(vecs[k].i0, vecs[k].i1);
      chk({vecs[k].name, "_no_early_issue"}, {bus.even_valid, bus.odd_valid}, 0);
      step();
      chk({vecs[k].name, "_even_valid"}, bus.even_valid, vecs[k].ev != 0);
      chk({vecs[k].name, "_even_info"}, bus.even_info,
          vecs[k].ev == 1 ? vecs[k].i0 : vecs[k].ev == 2 ? vecs[k].i1 : issue_info_t'('0));
      chk({vecs[k].name, "_odd_valid"}, bus.odd_valid, vecs[k].od != 0);
      chk({vecs[k].name, "_odd_info"}, bus.odd_info,
          vecs[k].od == 1 ? vecs[k].i0 : vecs[k].od == 2 ? vecs[k].i1 : issue_info_t'('0));
      chk({vecs[k].name, "_stall"}, bus.stall, 0);
      do_flush();
    end
    w = mk(1, 0, 2, 3, 1, 2, 0, 3'b110);
    r = mk(1, 1, 1, 6, 0, 3, 0, 3'b010);
    present(w, r);
    step();
    chk("raw2_first_even", bus.even_valid, 1);
    step();
    chk("raw2_stall", bus.stall, 1);
    chk("raw2_wait_odd", bus.odd_valid, 0);
    step();
    chk("raw2_odd_valid", bus.odd_valid, 1);
    chk("raw2_odd_info", bus.odd_info, r);
    chk("raw2_stall_done", bus.stall, 0);
    do_flush();
    w = mk(1, 0, 1, 3, 1, 0, 0, 3'b100);
    r = mk(1, 0, 1, 4, 2, 0, 0, 3'b100);
    present(w, r);
    step();
    chk("inorder_first", bus.even_info, w);
    step();
    chk("inorder_second_valid", bus.even_valid, 1);
    chk("inorder_second", bus.even_info, r);
    chk("inorder_stall", bus.stall, 0);
    do_flush();
    present(mk(1, 0, 7, 10, 1, 0, 0, 3'b100), '0);
    step();
    chk("sb_raw_writer", bus.even_valid, 1);
    tw = cyc;
    present(mk(0, 1, 1, 0, 10, 0, 0, 3'b100), '0);
    wait_valid("sb_raw", 1, tr);
    chk("sb_raw_gap", tr - tw, 7);
    do_flush();
    present(mk(1, 0, 7, 8, 1, 0, 0, 3'b100), '0);
    step();
    chk("waw_writer1", bus.even_valid, 1);
    tw = cyc;
    present(mk(1, 1, 4, 8, 2, 0, 0, 3'b100), '0);
    wait_valid("waw", 1, tr);
    chk("waw_gap", tr - tw, 7);
    tw = tr;
    present(mk(0, 0, 1, 0, 0, 8, 0, 3'b010), '0);
    wait_valid("waw_reader", 0, tr);
    chk("waw_reader_gap", tr - tw, 4);
    do_flush();
    present(mk(1, 0, 7, 3, 1, 0, 0, 3'b100), '0);
    step();
    r = mk(0, 0, 1, 0, 3, 0, 0, 3'b100);
    r2 = mk(0, 1, 1, 0, 0, 0, 3, 3'b001);
    present(r, r2);
    step();
    chk("flush_pre_stall", bus.stall, 1);
    do_flush();
    chk("flush_ready", bus.in_ready, 1);
    chk("flush_even_valid", bus.even_valid, 0);
    chk("flush_odd_valid", bus.odd_valid, 0);
    chk("flush_stall", bus.stall, 0);
    present(r2, '0);
    chk("flush_accept_stall", bus.stall, 0);
    step();
    chk("flush_reader_valid", bus.odd_valid, 1);
    chk("flush_reader_info", bus.odd_info, r2);
    chk("flush_reader_stall", bus.stall, 0);
    present(mk(1, 0, 7, 50, 1, 0, 0, 3'b100), '0);
    step();
    r = mk(0, 0, 1, 0, 50, 0, 0, 3'b100);
    r2 = mk(0, 1, 1, 0, 50, 0, 0, 3'b100);
    present(r, r2);
    step();
    chk("midrst_pre_stall", bus.stall, 1);
    reset = 1'b0;
    #1;
    chk("midrst_stall", bus.stall, 0);
    chk("midrst_valids", {bus.even_valid, bus.odd_valid}, 0);
    step();
    reset = 1'b1;
    chk("midrst_ready", bus.in_ready, 1);
    present(r2, '0);
    step();
    chk("midrst_reader_valid", bus.odd_valid, 1);
    chk("midrst_even_idle", bus.even_valid, 0);
    do_flush();
    w = mk(1, 0, 0, 60, 1, 0, 0, 3'b100);
    r = mk(0, 1, 1, 0, 60, 0, 0, 3'b100);
    present(w, r);
    step();
    chk("lat0_writer", bus.even_valid, 1);
    chk("lat0_reader_held", bus.odd_valid, 0);
    step();
    chk("lat0_reader", bus.odd_valid, 1);
    chk("lat0_stall", bus.stall, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
